// File: rtl/rx_sample_ctrl_if.sv
// Serial receive control bundle: raw line in, synchronized data and frame status out.
interface rx_sample_ctrl_if;
    logic serial_rx;
    logic sync_in;
    logic shift_enable;
    logic packet_done;
    logic framing_error;
    logic rx_busy;

    // Receiver side: samples the line, drives the shift-register controls and status.
    modport master (
        input  serial_rx,
        output sync_in,
        output shift_enable,
        output packet_done,
        output framing_error,
        output rx_busy
    );

    // Line/consumer side: drives the serial line, observes controls and status.
    modport slave (
        output serial_rx,
        input  sync_in,
        input  shift_enable,
        input  packet_done,
        input  framing_error,
        input  rx_busy
    );
endinterface

// File: rtl/rx_sample_ctrl.sv
// UART-style receive sampler: synchronizes the serial line, finds the start bit,
// and pulses shift_enable at the centre of each data bit for a downstream shift register.
module rx_sample_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter int unsigned NUM_BITS     = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    rx_sample_ctrl_if.master rx
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int unsigned BIT_W = $clog2(NUM_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] PRE_BIT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NUM_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        START_CHK,
        DATA,
        STOP
    } state_t;

    logic             sync_ff1;
    logic             sync_ff2;
    logic             sync_prev;
    logic             start_edge;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] bit_cnt_n;

    logic             shift_q;
    logic             shift_n;
    logic             done_q;
    logic             done_n;
    logic             ferr_q;
    logic             ferr_n;
    logic             busy_q;
    logic             busy_n;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection; all reset to idle-high.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_ff1  <= 1'b1;
            sync_ff2  <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync_ff1  <= rx.serial_rx;
            sync_ff2  <= sync_ff1;
            sync_prev <= sync_ff2;
        end
    end

    assign start_edge = sync_prev & ~sync_ff2;

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shift_q <= 1'b0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_cnt_n;
            shift_q <= shift_n;
            done_q  <= done_n;
            ferr_q  <= ferr_n;
            busy_q  <= busy_n;
        end
    end

    // Next state: cnt is the number of cycles since the last reference point
    // (start edge, start check, or previous bit sample); outputs are decided one cycle ahead.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CNT_ONE;
        bit_cnt_n = bit_cnt;
        shift_n   = 1'b0;
        done_n    = 1'b0;
        ferr_n    = ferr_q;

        case (state)
            IDLE: begin
                cnt_n     = '0;
                bit_cnt_n = '0;
                if (start_edge) begin
                    state_n = START_CHK;
                    cnt_n   = CNT_ONE;
                end
            end
            START_CHK: begin
                if (cnt == HALF_BIT) begin
                    if (!sync_ff2) begin
                        state_n = DATA;
                        cnt_n   = CNT_ONE;
                        ferr_n  = 1'b0;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
            end
            DATA: begin
                if (cnt == PRE_BIT) begin
                    shift_n = 1'b1;
                end
                if (cnt == FULL_BIT) begin
                    cnt_n = CNT_ONE;
                    if (bit_cnt == LAST_BIT) begin
                        state_n   = STOP;
                        bit_cnt_n = '0;
                    end else begin
                        bit_cnt_n = bit_cnt + BIT_ONE;
                    end
                end
            end
            STOP: begin
                if (cnt == FULL_BIT) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                    ferr_n  = ~sync_ff2;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    assign rx.sync_in       = sync_ff2;
    assign rx.shift_enable  = shift_q;
    assign rx.packet_done   = done_q;
    assign rx.framing_error = ferr_q;
    assign rx.rx_busy       = busy_q;

endmodule

// File: tb/tb_rx_sample_ctrl.sv
// Bench for rx_sample_ctrl: builds serial waveforms, derives expected pulses and levels
// from the frame timing rules, and checks the DUT through a queue-based monitor.
module tb_rx_sample_ctrl;

    localparam int CPB  = 10;
    localparam int NB   = 8;
    localparam int H    = CPB / 2;
    localparam int MAXC = 20000;

    typedef struct {
        int   cyc;
        logic val;
    } shift_exp_t;

    typedef struct {
        int         cyc;
        logic       ferr;
        logic [7:0] data;
    } done_exp_t;

    logic clk = 1'b0;
    logic n_rst;
    int   cyc = 0;

    rx_sample_ctrl_if rx_if ();

    rx_sample_ctrl #(
        .CLKS_PER_BIT (CPB),
        .NUM_BITS     (NB)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .rx    (rx_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    shift_exp_t sq[$];
    done_exp_t  dq[$];
    bit         exp_vld  [MAXC];
    logic       exp_busy [MAXC];
    logic       exp_ferr [MAXC];
    logic       exp_sync [MAXC];
    logic       mferr = 1'b0;

    bit         wave[$];
    int         n_shift;
    int         n_done;
    logic [7:0] shreg = '0;
    logic [7:0] rx_bytes[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int exp);
        checks++;
        errors++;
        $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    // Monitor: pops expected pulses when the DUT shows them, checks levels every cycle.
    always @(negedge clk) begin
        while (sq.size() > 0 && sq[0].cyc < cyc) begin
            fail_now("missing_shift_enable", 0, sq[0].cyc);
            void'(sq.pop_front());
        end
        while (dq.size() > 0 && dq[0].cyc < cyc) begin
            fail_now("missing_packet_done", 0, dq[0].cyc);
            void'(dq.pop_front());
        end
        if (rx_if.shift_enable && rx_if.packet_done)
            fail_now("shift_and_done_overlap", 1, 0);
        if (rx_if.shift_enable) begin
            n_shift++;
            shreg = {rx_if.sync_in, shreg[7:1]};
            if (sq.size() == 0) begin
                fail_now("unexpected_shift_enable", cyc, -1);
            end else begin
                shift_exp_t e;
                e = sq.pop_front();
                chk("shift_enable_cycle", cyc, e.cyc);
                chk("shift_bit_value", int'(rx_if.sync_in), int'(e.val));
            end
        end
        if (rx_if.packet_done) begin
            n_done++;
            rx_bytes.push_back(shreg);
            if (dq.size() == 0) begin
                fail_now("unexpected_packet_done", cyc, -1);
            end else begin
                done_exp_t d;
                d = dq.pop_front();
                chk("packet_done_cycle", cyc, d.cyc);
                chk("framing_error_at_done", int'(rx_if.framing_error), int'(d.ferr));
                chk("received_byte", int'(shreg), int'(d.data));
            end
        end
        if (cyc < MAXC && exp_vld[cyc]) begin
            chk("sync_in_level", int'(rx_if.sync_in), int'(exp_sync[cyc]));
            chk("rx_busy_level", int'(rx_if.rx_busy), int'(exp_busy[cyc]));
            chk("framing_error_level", int'(rx_if.framing_error), int'(exp_ferr[cyc]));
        end
    end

    // ---------------- waveform builders ----------------
    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) wave.push_back(1'b1);
    endtask

    task automatic add_low(input int n);
        for (int i = 0; i < n; i++) wave.push_back(1'b0);
    endtask

    task automatic add_frame(input logic [7:0] d, input bit stop);
        add_low(CPB);
        for (int k = 0; k < NB; k++)
            for (int i = 0; i < CPB; i++) wave.push_back(d[k]);
        for (int i = 0; i < CPB; i++) wave.push_back(stop);
    endtask

    task automatic add_glitch(input int base, input int k, input int off, input int len);
        for (int i = 0; i < len; i++) wave[base + CPB * (1 + k) + off + i] = 1'b0;
    endtask

    // ---------------- reference model ----------------
    function automatic logic sv(input bit s[], input int j);
        if (j < 0 || j >= s.size()) return 1'b1;
        return s[j];
    endfunction

    task automatic lvl(input int t, input logic b, input logic f);
        if (t >= 0 && t < MAXC) begin
            exp_busy[t] = b;
            exp_ferr[t] = f;
        end
    endtask

    // Line value driven in cycle B+i appears on sync_in in cycle B+i+2.
    task automatic model(input int base);
        int n;
        int j;
        bit s[];
        n = wave.size();
        s = new[n + 2];
        s[0] = 1'b1;
        s[1] = 1'b1;
        for (int i = 0; i < n; i++) s[i + 2] = wave[i];
        for (int i = 0; i < n + 2; i++) begin
            if (base + i < MAXC) begin
                exp_vld[base + i]  = 1'b1;
                exp_sync[base + i] = s[i];
            end
        end
        j = 0;
        while (j < n + 2) begin
            if (j > 0 && s[j] == 1'b0 && s[j - 1] == 1'b1) begin
                int e;
                e = j;
                lvl(base + e, 1'b0, mferr);
                for (int t = e + 1; t <= e + H; t++) lvl(base + t, 1'b1, mferr);
                if (sv(s, e + H) == 1'b1) begin
                    j = e + H + 1;
                end else begin
                    int         st;
                    logic [7:0] d;
                    d  = '0;
                    st = e + H + (NB + 1) * CPB;
                    for (int k = 0; k < NB; k++) begin
                        int ts;
                        ts   = e + H + (k + 1) * CPB;
                        d[k] = sv(s, ts);
                        sq.push_back('{cyc: base + ts, val: sv(s, ts)});
                    end
                    for (int t = e + H + 1; t <= st; t++) lvl(base + t, 1'b1, 1'b0);
                    mferr = ~sv(s, st);
                    dq.push_back('{cyc: base + st + 1, ferr: mferr, data: d});
                    j = st + 1;
                end
            end else begin
                lvl(base + j, 1'b0, mferr);
                j++;
            end
        end
    endtask

    // Drives the current wave; abort_idx >= 0 asserts reset at that line index.
    task automatic run_phase(input int abort_idx);
        int b;
        @(posedge clk);
        #1;
        b = cyc;
        model(b);
        for (int i = 0; i < wave.size(); i++) begin
            if (i == abort_idx) begin
                n_rst = 1'b0;
                rx_if.serial_rx = 1'b1;
                #1;
                chk("abort_sync_in", int'(rx_if.sync_in), 1);
                chk("abort_shift_enable", int'(rx_if.shift_enable), 0);
                chk("abort_packet_done", int'(rx_if.packet_done), 0);
                chk("abort_framing_error", int'(rx_if.framing_error), 0);
                chk("abort_rx_busy", int'(rx_if.rx_busy), 0);
                for (int c = cyc; c < b + wave.size() + 3 && c < MAXC; c++) exp_vld[c] = 1'b0;
                sq.delete();
                dq.delete();
                mferr = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                n_rst = 1'b1;
                repeat (6) @(posedge clk);
                #1;
                break;
            end
            rx_if.serial_rx = wave[i];
            @(posedge clk);
            #1;
        end
        wave.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        n_shift = 0;
        n_done  = 0;
        rx_bytes.delete();
    endtask

    task automatic phase_summary(input string name, input int shifts, input int dones,
                                 input int b0, input int b1, input int ferr);
        chk({name, "_shift_count"}, n_shift, shifts);
        chk({name, "_done_count"}, n_done, dones);
        if (dones >= 1) chk({name, "_byte0"}, (rx_bytes.size() > 0) ? int'(rx_bytes[0]) : -1, b0);
        if (dones >= 2) chk({name, "_byte1"}, (rx_bytes.size() > 1) ? int'(rx_bytes[1]) : -1, b1);
        chk({name, "_framing_error"}, int'(rx_if.framing_error), ferr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout: got %0d expected 0", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        logic [7:0] d;
        bit st;

        n_rst = 1'b0;
        rx_if.serial_rx = 1'b1;
        clr_counts();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_sync_in", int'(rx_if.sync_in), 1);
        chk("reset_shift_enable", int'(rx_if.shift_enable), 0);
        chk("reset_packet_done", int'(rx_if.packet_done), 0);
        chk("reset_framing_error", int'(rx_if.framing_error), 0);
        chk("reset_rx_busy", int'(rx_if.rx_busy), 0);
        n_rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // 0xA5 with good stop bit.
        clr_counts();
        add_idle(4); add_frame(8'hA5, 1'b1); add_idle(20);
        run_phase(-1);
        phase_summary("a5", 8, 1, 8'hA5, 0, 0);

        // 0x3C with bad stop bit, then a 3-cycle false start.
        clr_counts();
        add_idle(4); add_frame(8'h3C, 1'b0); add_idle(12); add_low(3); add_idle(20);
        run_phase(-1);
        phase_summary("3c_bad_stop_false_start", 8, 1, 8'h3C, 0, 1);

        // Valid 0x00 clears the framing error.
        clr_counts();
        add_idle(4); add_frame(8'h00, 1'b1); add_idle(20);
        run_phase(-1);
        phase_summary("00_clear", 8, 1, 8'h00, 0, 0);

        // Back-to-back 0xFF and 0x01.
        clr_counts();
        add_idle(4); add_frame(8'hFF, 1'b1); add_frame(8'h01, 1'b1); add_idle(20);
        run_phase(-1);
        phase_summary("ff_01_b2b", 16, 2, 8'hFF, 8'h01, 0);

        // Glitches inside data bits are ignored.
        clr_counts();
        add_idle(4); base = wave.size(); add_frame(8'hFF, 1'b1);
        add_glitch(base, 3, 2, 2); add_glitch(base, 6, 7, 1);
        add_idle(20);
        run_phase(-1);
        phase_summary("glitch", 8, 1, 8'hFF, 0, 0);

        // Set framing error, then reset during data bit 4 of the next frame.
        clr_counts();
        add_idle(4); add_frame(8'h3C, 1'b0); add_idle(20);
        run_phase(-1);
        chk("pre_reset_framing_error", int'(rx_if.framing_error), 1);
        clr_counts();
        add_idle(4); add_frame(8'h5A, 1'b1); add_idle(20);
        run_phase(4 + CPB * 5 + 3);
        phase_summary("reset_abort", 4, 0, 0, 0, 0);

        // Fresh frame after reset.
        clr_counts();
        add_idle(4); add_frame(8'h81, 1'b1); add_idle(20);
        run_phase(-1);
        phase_summary("81_after_reset", 8, 1, 8'h81, 0, 0);

        // Randomized traffic: data, stop bit, gaps, false starts, glitches.
        for (int p = 0; p < 8; p++) begin
            add_idle($urandom_range(3, 8));
            for (int f = 0; f < 5; f++) begin
                d  = 8'($urandom);
                st = ($urandom % 5) != 0;
                base = wave.size();
                add_frame(d, st);
                if ($urandom % 3 == 0) begin
                    int k;
                    k = $urandom_range(0, NB - 1);
                    if (d[k]) add_glitch(base, k, ($urandom % 2) ? $urandom_range(1, 2) : 7,
                                         $urandom_range(1, 2));
                end
                add_idle(st ? $urandom_range(0, 4) : $urandom_range(1, 4));
                if ($urandom % 4 == 0) begin
                    add_idle(2);
                    add_low($urandom_range(1, H - 1));
                    add_idle(H + 4);
                end
            end
            add_idle(20);
            run_phase(-1);
        end

        repeat (30) @(posedge clk);
        #1;
        chk("shift_queue_drained", sq.size(), 0);
        chk("done_queue_drained", dq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
